// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU execution unit.
// Holds the data/tag widths, RV32I opcode encodings and the CDB result record.
// Imported by alu_compute and alu.
package alu_pkg;

  localparam int DATA_WID = 32;
  localparam int ROB_WID  = 4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // One broadcast on the common data bus.
  typedef struct packed {
    logic [ROB_WID-1:0]  rob_pos;
    logic [DATA_WID-1:0] val;
    logic                jump;
    logic [DATA_WID-1:0] target_pc;
  } cdb_res_t;

endpackage

// File: rtl/alu_compute.sv
// Purely combinational RV32I integer datapath: opcode/funct/operands -> {value, jump, target}.
// Ports: opcode_i/funct3_i/funct7_i select the operation; val1_i, val2_i, imm_i, pc_i are operands;
//        val_o is the rd value, jump_o the taken flag, target_o the control-transfer target.
// Unrecognised opcodes produce all-zero outputs so the ROB entry can still retire.
module alu_compute
  import alu_pkg::*;
(
  input  logic [6:0]          opcode_i,
  input  logic [2:0]          funct3_i,
  input  logic                funct7_i,
  input  logic [DATA_WID-1:0] val1_i,
  input  logic [DATA_WID-1:0] val2_i,
  input  logic [DATA_WID-1:0] imm_i,
  input  logic [DATA_WID-1:0] pc_i,
  output logic [DATA_WID-1:0] val_o,
  output logic                jump_o,
  output logic [DATA_WID-1:0] target_o
);

  logic [DATA_WID-1:0] op_b;
  logic [4:0]          shamt;
  logic                is_op;

  assign is_op = (opcode_i == OPC_OP);
  assign op_b  = is_op ? val2_i : imm_i;
  assign shamt = op_b[4:0];

  always_comb begin
    val_o    = '0;
    jump_o   = 1'b0;
    target_o = '0;
    case (opcode_i)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3_i)
          // funct7 bit 5 means SUB only for register-register; ADDI ignores it.
          3'd0: val_o = (is_op && funct7_i) ? (val1_i - op_b) : (val1_i + op_b);
          3'd1: val_o = val1_i << shamt;
          3'd2: val_o = {{(DATA_WID-1){1'b0}}, ($signed(val1_i) < $signed(op_b))};
          3'd3: val_o = {{(DATA_WID-1){1'b0}}, (val1_i < op_b)};
          3'd4: val_o = val1_i ^ op_b;
          3'd5: val_o = funct7_i ? DATA_WID'($signed(val1_i) >>> shamt) : (val1_i >> shamt);
          3'd6: val_o = val1_i | op_b;
          default: val_o = val1_i & op_b;
        endcase
      end
      OPC_LUI:   val_o = imm_i;
      OPC_AUIPC: val_o = pc_i + imm_i;
      OPC_JAL: begin
        val_o    = pc_i + 32'd4;
        jump_o   = 1'b1;
        target_o = pc_i + imm_i;
      end
      OPC_JALR: begin
        val_o    = pc_i + 32'd4;
        jump_o   = 1'b1;
        target_o = (val1_i + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        target_o = pc_i + imm_i;
        case (funct3_i)
          3'd0:    jump_o = (val1_i == val2_i);
          3'd1:    jump_o = (val1_i != val2_i);
          3'd4:    jump_o = ($signed(val1_i) <  $signed(val2_i));
          3'd5:    jump_o = ($signed(val1_i) >= $signed(val2_i));
          3'd6:    jump_o = (val1_i <  val2_i);
          3'd7:    jump_o = (val1_i >= val2_i);
          default: jump_o = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu.sv
// ALU execution unit: computes one RV32I integer op per cycle, queues results in order, broadcasts on the CDB.
// Ports: clk/rst (sync, active-low)/rdy (global enable)/rollback; alu_* dispatch from the RS, alu_full stall back;
//        cdb_req/cdb_grant handshake with cdb_rob_pos/cdb_val/cdb_jump/cdb_target_pc showing the FIFO head.
// Option: define ALU_BYPASS_EN to forward a result straight to the CDB in the dispatch cycle when the FIFO is empty.
module alu
  import alu_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                alu_en,
  input  logic [6:0]          alu_opcode,
  input  logic [2:0]          alu_funct3,
  input  logic                alu_funct7,
  input  logic [DATA_WID-1:0] alu_val1,
  input  logic [DATA_WID-1:0] alu_val2,
  input  logic [DATA_WID-1:0] alu_imm,
  input  logic [DATA_WID-1:0] alu_pc,
  input  logic [ROB_WID-1:0]  alu_rob_pos,
  output logic                alu_full,
  output logic                cdb_req,
  input  logic                cdb_grant,
  output logic [ROB_WID-1:0]  cdb_rob_pos,
  output logic [DATA_WID-1:0] cdb_val,
  output logic                cdb_jump,
  output logic [DATA_WID-1:0] cdb_target_pc
);

  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  cdb_res_t      mem_q [ALU_FIFO_DEPTH];

  cdb_res_t new_res, out_res;
  logic     empty, full, push, pop, byp;

  alu_compute u_compute (
    .opcode_i (alu_opcode),
    .funct3_i (alu_funct3),
    .funct7_i (alu_funct7),
    .val1_i   (alu_val1),
    .val2_i   (alu_val2),
    .imm_i    (alu_imm),
    .pc_i     (alu_pc),
    .val_o    (new_res.val),
    .jump_o   (new_res.jump),
    .target_o (new_res.target_pc)
  );
  assign new_res.rob_pos = alu_rob_pos;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(ALU_FIFO_DEPTH));
  // One slot of slack absorbs the instruction the RS already has in flight.
  assign alu_full = (count_q >= CW'(ALU_FIFO_DEPTH - 1));

`ifdef ALU_BYPASS_EN
  assign byp = rdy && empty && alu_en && !rollback;
`else
  assign byp = 1'b0;
`endif

  assign pop  = rdy && !rollback && cdb_grant && !empty;
  // A bypassed result that is granted in the same cycle has already been broadcast.
  assign push = rdy && !rollback && alu_en && (!full || pop) && !(byp && cdb_grant);

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (rdy) begin
      if (rollback) begin
        count_d = '0;
        head_d  = '0;
        tail_d  = '0;
      end else begin
        // Depth is a power of two, so pointer increments wrap for free.
        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[tail_q] <= new_res;
  end

  always_comb begin
    out_res = '0;
    if (!empty)   out_res = mem_q[head_q];
    else if (byp) out_res = new_res;
  end

`ifdef ALU_BYPASS_EN
  assign cdb_req = (!empty || byp) && !rollback;
`else
  assign cdb_req = !empty;
`endif

  assign cdb_rob_pos   = out_res.rob_pos;
  assign cdb_val       = out_res.val;
  assign cdb_jump      = out_res.jump;
  assign cdb_target_pc = out_res.target_pc;

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  import alu_pkg::ROB_WID;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback = 1'b0;
  logic        alu_en = 1'b0;
  logic [6:0]  alu_opcode = '0;
  logic [2:0]  alu_funct3 = '0;
  logic        alu_funct7 = 1'b0;
  logic [31:0] alu_val1 = '0, alu_val2 = '0, alu_imm = '0, alu_pc = '0;
  logic [ROB_WID-1:0] alu_rob_pos = '0;
  logic        alu_full, cdb_req, cdb_grant = 1'b0, cdb_jump;
  logic [ROB_WID-1:0] cdb_rob_pos;
  logic [31:0] cdb_val, cdb_target_pc;

  alu #(.ALU_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
    .alu_rob_pos(alu_rob_pos), .alu_full(alu_full), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val),
    .cdb_jump(cdb_jump), .cdb_target_pc(cdb_target_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rob;
    logic [31:0] val;
    logic        jump;
    logic [31:0] tgt;
  } exp_t;

  exp_t model_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference semantics straight from the RV32I rules.
  function automatic exp_t ref_exec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    input logic [31:0] a, input logic [31:0] b2, input logic [31:0] imm,
                                    input logic [31:0] pc, input logic [31:0] rob);
    exp_t r;
    logic [31:0] b;
    int unsigned sh;
    r.rob = rob; r.val = 0; r.jump = 0; r.tgt = 0;
    b  = (op == 7'h33) ? b2 : imm;
    sh = b % 32;
    case (op)
      7'h33, 7'h13:
        case (f3)
          3'd0: r.val = (op == 7'h33 && f7) ? a - b : a + b;
          3'd1: r.val = a << sh;
          3'd2: r.val = ($signed(a) < $signed(b)) ? 1 : 0;
          3'd3: r.val = (a < b) ? 1 : 0;
          3'd4: r.val = a ^ b;
          3'd5: r.val = f7 ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: r.val = a | b;
          default: r.val = a & b;
        endcase
      7'h37: r.val = imm;
      7'h17: r.val = pc + imm;
      7'h6f: begin r.val = pc + 4; r.jump = 1; r.tgt = pc + imm; end
      7'h67: begin r.val = pc + 4; r.jump = 1; r.tgt = (a + imm) & 32'hFFFF_FFFE; end
      7'h63: begin
        r.tgt = pc + imm;
        case (f3)
          3'd0: r.jump = (a == b2);
          3'd1: r.jump = (a != b2);
          3'd4: r.jump = ($signed(a) < $signed(b2));
          3'd5: r.jump = ($signed(a) >= $signed(b2));
          3'd6: r.jump = (a < b2);
          3'd7: r.jump = (a >= b2);
          default: r.jump = 0;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [31:0] pc, input int rob);
    alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
    alu_val1 = a; alu_val2 = b; alu_imm = imm; alu_pc = pc; alu_rob_pos = ROB_WID'(rob);
  endtask

  task automatic check_outputs();
    exp_t e;
    int   n = model_q.size();
    e.rob = 0; e.val = 0; e.jump = 0; e.tgt = 0;
    if (n > 0) e = model_q[0];
    chk_eq("cdb_req", {31'b0, cdb_req}, (n > 0) ? 1 : 0);
    chk_eq("alu_full", {31'b0, alu_full}, (n >= 3) ? 1 : 0);
    chk_eq("cdb_rob_pos", 32'(cdb_rob_pos), e.rob);
    chk_eq("cdb_val", cdb_val, e.val);
    chk_eq("cdb_jump", {31'b0, cdb_jump}, {31'b0, e.jump});
    chk_eq("cdb_target_pc", cdb_target_pc, e.tgt);
  endtask

  // Drive one cycle, advance the model at the edge, check half a cycle later.
  task automatic cycle(input logic en, input logic g, input logic rb, input logic rdy_v, input logic rst_v);
    exp_t nr;
    int   n;
    bit   popped;
    alu_en = en; cdb_grant = g; rollback = rb; rdy = rdy_v; rst = rst_v;
    nr = ref_exec(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc, 32'(alu_rob_pos));
    @(posedge clk);
    n = model_q.size();
    if (!rst_v) model_q.delete();
    else if (rdy_v) begin
      if (rb) model_q.delete();
      else begin
        popped = 0;
        if (g && n > 0) begin void'(model_q.pop_front()); popped = 1; end
        if (en) begin
          chk_eq("no_overflow_dispatch", (n == 4 && !popped) ? 1 : 0, 0);
          if (n < 4 || popped) model_q.push_back(nr);
        end
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // Reset
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 0, 1, 0);
    chk_eq("rst_req", {31'b0, cdb_req}, 0);
    chk_eq("rst_full", {31'b0, alu_full}, 0);
    chk_eq("rst_val", cdb_val, 0);

    // ADD, grant held high
    set_op(7'h33, 0, 0, 5, 7, 0, 0, 3);
    cycle(1, 1, 0, 1, 1);
    chk_eq("add_req", {31'b0, cdb_req}, 1);
    chk_eq("add_val", cdb_val, 12);
    chk_eq("add_rob", 32'(cdb_rob_pos), 3);

    // SRA then SRL
    set_op(7'h33, 5, 1, 32'h8000_0000, 4, 0, 0, 1);
    cycle(1, 1, 0, 1, 1);
    chk_eq("sra_val", cdb_val, 32'hF800_0000);
    set_op(7'h33, 5, 0, 32'h8000_0000, 4, 0, 0, 2);
    cycle(1, 1, 0, 1, 1);
    chk_eq("srl_val", cdb_val, 32'h0800_0000);

    // BEQ taken / not taken
    set_op(7'h63, 0, 0, 9, 9, 8, 32'h100, 4);
    cycle(1, 1, 0, 1, 1);
    chk_eq("beq_jump", {31'b0, cdb_jump}, 1);
    chk_eq("beq_tgt", cdb_target_pc, 32'h108);
    set_op(7'h63, 0, 0, 9, 10, 8, 32'h100, 5);
    cycle(1, 1, 0, 1, 1);
    chk_eq("beq_nt_jump", {31'b0, cdb_jump}, 0);

    // JALR
    set_op(7'h67, 0, 0, 32'h1003, 0, 2, 32'h200, 6);
    cycle(1, 1, 0, 1, 1);
    chk_eq("jalr_val", cdb_val, 32'h204);
    chk_eq("jalr_tgt", cdb_target_pc, 32'h1004);
    chk_eq("jalr_jump", {31'b0, cdb_jump}, 1);
    cycle(0, 1, 0, 1, 1);
    chk_eq("drain_req", {31'b0, cdb_req}, 0);

    // Backpressure and in-order drain
    for (int i = 1; i <= 3; i++) begin
      set_op(7'h13, 0, 0, 100, 0, i, 0, i);
      cycle(1, 0, 0, 1, 1);
    end
    chk_eq("bp_full", {31'b0, alu_full}, 1);
    chk_eq("bp_head", 32'(cdb_rob_pos), 1);
    cycle(0, 1, 0, 1, 1);
    chk_eq("bp_full_drop", {31'b0, alu_full}, 0);
    chk_eq("bp_head2", 32'(cdb_rob_pos), 2);
    cycle(0, 1, 0, 1, 1);
    chk_eq("bp_head3", cdb_val, 103);
    cycle(0, 1, 0, 1, 1);

    // Rollback with a same-cycle dispatch
    set_op(7'h37, 0, 0, 0, 0, 32'hABCD_0000, 0, 7);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 0, 0, 1, 1);
    set_op(7'h33, 0, 0, 5, 7, 0, 0, 9);
    cycle(1, 0, 1, 1, 1);
    chk_eq("rb_req", {31'b0, cdb_req}, 0);
    chk_eq("rb_full", {31'b0, alu_full}, 0);
    set_op(7'h33, 0, 0, 5, 7, 0, 0, 5);
    cycle(1, 1, 0, 1, 1);
    chk_eq("post_rb_val", cdb_val, 12);
    chk_eq("post_rb_rob", 32'(cdb_rob_pos), 5);
    cycle(0, 1, 0, 1, 1);

    // rdy low freezes everything
    set_op(7'h17, 0, 0, 0, 0, 16, 32'h40, 11);
    cycle(1, 0, 0, 1, 1);
    cycle(1, 1, 1, 0, 1);
    chk_eq("rdy_hold_val", cdb_val, 32'h50);

    // Reset mid-drain
    for (int i = 0; i < 2; i++) cycle(1, 0, 0, 1, 1);
    cycle(0, 1, 0, 1, 0);
    chk_eq("rst_drain_req", {31'b0, cdb_req}, 0);
    chk_eq("rst_drain_val", cdb_val, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h00};
      logic en, g, rb, rv;
      set_op(ops[$urandom_range(0, 8)], 3'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             $urandom, $urandom, $urandom_range(0, 15));
      g  = 1'($urandom_range(0, 1));
      en = 1'($urandom_range(0, 1));
      rb = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 9) != 0);
      if (model_q.size() == 4 && !g) en = 1'b0;
      cycle(en, g, rb, rv, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
